// File: rtl/reg_skid_slice.sv
// ---------------------------------------------------------------------------
// reg_skid_slice
//
// Two-entry valid/ready register slice (skid buffer). Both the forward path
// (o_data, o_valid) and the backward path (o_ready) come straight from flops,
// so neither path has combinational logic between upstream and downstream.
// One transfer per cycle is sustained while downstream is ready. When
// downstream stalls, the word in flight is caught in the skid register.
//
// Ports
//   i_clk    in   1           clock, rising edge
//   i_rst_n  in   1           asynchronous active-low reset
//   i_valid  in   1           upstream word present on i_data
//   o_ready  out  1           slice accepts a word this cycle (flop)
//   i_data   in   DATA_WIDTH  upstream payload
//   o_valid  out  1           o_data holds a valid word (flop)
//   i_ready  in   1           downstream accepts o_data this cycle
//   o_data   out  DATA_WIDTH  payload to downstream (main data flop)
//   o_count  out  2           words held: 0, 1 or 2
// ---------------------------------------------------------------------------
module reg_skid_slice #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [1:0]            o_count
);

  // State is encoded directly as {skid_vld, main_vld} so the valid bits are
  // the state flops themselves. 2'b10 cannot be reached from reset.
  typedef enum logic [1:0] {
    EMPTY   = 2'b00,
    BUSY    = 2'b01,
    ILLEGAL = 2'b10,
    FULL    = 2'b11
  } state_t;

  state_t                state;
  state_t                state_n;
  logic                  ready_q;
  logic [DATA_WIDTH-1:0] main_data;
  logic [DATA_WIDTH-1:0] skid_data;

  logic main_vld;
  logic skid_vld;
  logic in_fire;
  logic out_fire;

  // Load strobes for the data flops.
  logic load_main_in;
  logic load_main_skid;
  logic load_skid;

  assign main_vld = state[0];
  assign skid_vld = state[1];

  assign in_fire  = i_valid && ready_q;
  assign out_fire = main_vld && i_ready;

  // ---------------------------------------------------------------------------
  // Next-state and load decode
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    state_n        = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;

    unique case (state)
      EMPTY: begin
        if (in_fire) begin
          load_main_in = 1'b1;
          state_n      = BUSY;
        end
      end

      BUSY: begin
        if (in_fire && out_fire) begin
          // Main drains and refills on the same edge.
          load_main_in = 1'b1;
        end else if (in_fire) begin
          // Downstream stalled: the word in flight goes into the skid.
          load_skid = 1'b1;
          state_n   = FULL;
        end else if (out_fire) begin
          state_n = EMPTY;
        end
      end

      FULL: begin
        // ready_q is low here, so upstream cannot fire.
        if (out_fire) begin
          load_main_skid = 1'b1;
          state_n        = BUSY;
        end
      end

      ILLEGAL: begin
        state_n = EMPTY;
      end

      default: begin
        state_n = EMPTY;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, ready and data registers
  // ---------------------------------------------------------------------------
  // o_ready is its own flop: it loads the inverse of the next skid valid, so
  // it always equals !skid_vld without a gate in front of the output.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values, independent of statement order.
      state   <= EMPTY;
      ready_q <= 1'b1;
    end else begin
      state   <= state_n;
      ready_q <= !state_n[1];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      // NOTE: the data registers are reset as well so o_data reads as zero
      // during and after reset instead of carrying a stale word.
      main_data <= '0;
      skid_data <= '0;
    end else begin
      if (load_main_in) begin
        main_data <= i_data;
      end else if (load_main_skid) begin
        main_data <= skid_data;
      end
      if (load_skid) begin
        skid_data <= i_data;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign o_ready = ready_q;
  assign o_valid = main_vld;
  assign o_data  = main_data;
  assign o_count = {1'b0, main_vld} + {1'b0, skid_vld};

endmodule

// File: tb/tb_reg_skid_slice.sv
// ---------------------------------------------------------------------------
// tb_reg_skid_slice
//
// Directed bench for reg_skid_slice: reset/idle, single word, streaming,
// backpressure fill and drain, a randomised handshake run with an in-order
// scoreboard, and an asynchronous reset taken while the slice is full.
// A small two-deep FIFO reference model supplies the expected outputs on
// every cycle. Hand-computed constants back up the directed steps.
// ---------------------------------------------------------------------------
module tb_reg_skid_slice;

  localparam int DW = 32;

  logic          i_clk;
  logic          i_rst_n;
  logic          i_valid;
  logic          o_ready;
  logic [DW-1:0] i_data;
  logic          o_valid;
  logic          i_ready;
  logic [DW-1:0] o_data;
  logic [1:0]    o_count;

  int n_checks;
  int n_fail;

  // Reference model: the words the slice should currently hold, oldest first.
  logic [DW-1:0] model_q[$];

  reg_skid_slice #(.DATA_WIDTH(DW)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_data  (i_data),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_data  (o_data),
    .o_count (o_count)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic check(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare the outputs against the model, clock one edge, then update
  // the model with the transfers that edge performed. The caller sets the
  // inputs before the call; the task returns 1 ns after the edge.
  task automatic cycle(input string tag);
    logic exp_valid;
    logic exp_ready;
    logic in_fire;
    logic out_fire;
    exp_valid = (model_q.size() > 0);
    exp_ready = (model_q.size() < 2);
    check({tag, " o_valid"}, DW'(o_valid), DW'(exp_valid));
    check({tag, " o_ready"}, DW'(o_ready), DW'(exp_ready));
    check({tag, " o_count"}, DW'(o_count), DW'(model_q.size()));
    if (exp_valid) check({tag, " o_data"}, o_data, model_q[0]);
    in_fire  = i_valid && exp_ready;
    out_fire = exp_valid && i_ready;
    @(posedge i_clk);
    if (out_fire) void'(model_q.pop_front());
    if (in_fire)  model_q.push_back(i_data);
    #1;
  endtask

  initial begin
    int            rx_count;
    logic [DW-1:0] next_word;
    logic [DW-1:0] rx_next;
    logic [DW-1:0] held;
    logic          stall;
    int            budget;

    n_checks = 0;
    n_fail   = 0;
    i_rst_n  = 1'b0;
    i_valid  = 1'b0;
    i_ready  = 1'b0;
    i_data   = '0;

    // ---- Reset and idle -----------------------------------------------------
    #20;
    check("rst o_valid", DW'(o_valid), 32'd0);
    check("rst o_ready", DW'(o_ready), 32'd1);
    check("rst o_data",  o_data,       32'h00000000);
    check("rst o_count", DW'(o_count), 32'd0);
    #2 i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    repeat (2) cycle("idle");
    check("idle o_data", o_data, 32'h00000000);

    // ---- Single word --------------------------------------------------------
    i_ready = 1'b1;
    i_valid = 1'b1;
    i_data  = 32'hFFFF0000;
    cycle("single in");
    i_valid = 1'b0;
    check("single o_valid", DW'(o_valid), 32'd1);
    check("single o_data",  o_data,       32'hFFFF0000);
    cycle("single out");
    check("single drained", DW'(o_count), 32'd0);

    // ---- Streaming ----------------------------------------------------------
    for (int i = 1; i <= 16; i++) begin
      i_valid = 1'b1;
      i_data  = DW'(i);
      cycle("stream");
      check("stream o_data",  o_data,       DW'(i));
      check("stream o_valid", DW'(o_valid), 32'd1);
      check("stream o_ready", DW'(o_ready), 32'd1);
    end
    i_valid = 1'b0;
    cycle("stream tail");
    check("stream drained", DW'(o_count), 32'd0);

    // ---- Backpressure fill and drain ----------------------------------------
    i_ready = 1'b0;
    i_valid = 1'b1;
    i_data  = 32'hFFFF00FF;
    cycle("bp w0");
    i_data  = 32'hFFFFFFFF;
    cycle("bp w1");
    check("bp count",  DW'(o_count), 32'd2);
    check("bp ready",  DW'(o_ready), 32'd0);
    check("bp data",   o_data,       32'hFFFF00FF);
    i_data  = 32'h12345678;
    cycle("bp w2 blocked");
    cycle("bp w2 blocked");
    check("bp still full", DW'(o_count), 32'd2);
    check("bp data held",  o_data,       32'hFFFF00FF);
    i_ready = 1'b1;
    cycle("bp drain0");
    check("bp out1 data",  o_data,       32'hFFFFFFFF);
    check("bp out1 count", DW'(o_count), 32'd1);
    check("bp ready back", DW'(o_ready), 32'd1);
    cycle("bp accept w2");
    i_valid = 1'b0;
    check("bp out2 data",  o_data,       32'h12345678);
    cycle("bp drain2");
    check("bp drained", DW'(o_count), 32'd0);

    // ---- Random handshake ---------------------------------------------------
    next_word = 32'h00001000;
    rx_next   = 32'h00001000;
    rx_count  = 0;
    budget    = 20000;
    while ((rx_count < 1000) && (budget > 0)) begin
      budget--;
      i_valid = (next_word < 32'h00001000 + 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
      i_data  = next_word;
      i_ready = 1'($urandom_range(0, 1));
      if ((model_q.size() > 0) && i_ready) begin
        check("rand order", o_data, rx_next);
        rx_next++;
        rx_count++;
      end
      if (i_valid && (model_q.size() < 2)) next_word++;
      stall = o_valid && !i_ready;
      held  = o_data;
      cycle("rand");
      if (stall) check("rand stable", o_data, held);
    end
    check("rand budget", DW'(budget > 0), 32'd1);
    check("rand words",  DW'(rx_count),   32'd1000);
    i_valid = 1'b0;
    i_ready = 1'b1;
    repeat (3) cycle("rand tail");

    // ---- Reset while FULL ---------------------------------------------------
    i_ready = 1'b0;
    i_valid = 1'b1;
    i_data  = 32'hCAFE0001;
    cycle("mr w0");
    i_data  = 32'hCAFE0002;
    cycle("mr w1");
    i_valid = 1'b0;
    check("mr full", DW'(o_count), 32'd2);
    #3 i_rst_n = 1'b0;
    #1;
    check("mr o_valid", DW'(o_valid), 32'd0);
    check("mr o_count", DW'(o_count), 32'd0);
    check("mr o_ready", DW'(o_ready), 32'd1);
    check("mr o_data",  o_data,       32'h00000000);
    model_q.delete();
    #2 i_rst_n = 1'b1;
    i_ready = 1'b1;
    repeat (3) cycle("mr idle");
    i_valid = 1'b1;
    i_data  = 32'hAAAA5555;
    cycle("mr new");
    i_valid = 1'b0;
    check("mr new data", o_data, 32'hAAAA5555);
    cycle("mr new out");
    check("mr new drained", DW'(o_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
